id_scoreboard: RTL and testbench

- Parametrised hazard and forwarding unit for the decode stage.
- Replaces the fixed three-stage EX/MEM/WB bypass compare with a scoreboard. It keeps a per-register pending-write counter, forwards from a configurable number of downstream stages, and stalls on any not-yet-available producer. This covers load-use and multi-cycle mul/div results.
- Sits between the ID decode logic, the regfile read ports and the downstream stages' rf buses.

---
 rtl/id_scoreboard.sv | 113 +++++++++++
 tb/tb_id_scoreboard.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage hazard detection and operand forwarding via a per-register pending-write scoreboard.
// Latency: operand select and stall are combinational (0 cycles); counter, err and stall_cnt updates appear the cycle after the edge.
// Backpressure: stall holds ID whenever a needed producer is not yet ready or a destination counter is full.
module id_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NFWD = 3,
  parameter int CW   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AW-1:0]              rs1_addr,
  input  logic                       rs1_need,
  input  logic [AW-1:0]              rs2_addr,
  input  logic                       rs2_need,
  input  logic [DW-1:0]              rf_rdata1,
  input  logic [DW-1:0]              rf_rdata2,
  input  logic                       id_valid,
  input  logic                       dst_we,
  input  logic [AW-1:0]              dst_addr,
  input  logic                       issue_fire,
  input  logic [NFWD*(2+AW+DW)-1:0]  fwd_bus,
  input  logic                       wb_fire,
  input  logic [AW-1:0]              wb_addr,
  output logic [DW-1:0]              rs1_value,
  output logic [DW-1:0]              rs2_value,
  output logic                       stall,
  output logic [NREG-1:0]            pending,
  output logic                       err,
  output logic [31:0]                stall_cnt
);

  // One forwarding slice: {we, ready, waddr, wdata}, wdata in the low bits.
  localparam int SW = 2 + AW + DW;
  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0] cnt [NREG];
  logic [DW:0]   pick1;
  logic [DW:0]   pick2;
  logic          hazard1;
  logic          hazard2;
  logic          dst_full;

  // Returns {hazard, value}. Lower source index is younger and wins; an
  // unexposed in-flight producer (counter nonzero, no bus match) is a hazard.
  function automatic logic [DW:0] pick(input logic [AW-1:0] a,
                                       input logic [DW-1:0] rf,
                                       input logic          busy,
                                       input logic [NFWD*SW-1:0] bus);
    logic          found;
    logic [DW:0]   r;
    logic [SW-1:0] s;
    found = 1'b0;
    r     = {1'b0, rf};
    if (a == '0) begin
      r = '0;
    end else begin
      for (int i = 0; i < NFWD; i++) begin
        s = bus[i*SW +: SW];
        if (!found && s[SW-1] && (s[DW +: AW] == a)) begin
          found = 1'b1;
          r = s[SW-2] ? {1'b0, s[DW-1:0]} : {1'b1, {DW{1'b0}}};
        end
      end
      if (!found && busy) r = {1'b1, {DW{1'b0}}};
    end
    return r;
  endfunction

  // Pending-nonzero view of every counter; r0 is never counted so stays 0.
  always_comb begin
    pending = '0;
    for (int r = 0; r < NREG; r++) pending[r] = (cnt[r] != '0);
  end

  // Operand selection and stall decision.
  always_comb begin
    pick1     = pick(rs1_addr, rf_rdata1, pending[rs1_addr], fwd_bus);
    pick2     = pick(rs2_addr, rf_rdata2, pending[rs2_addr], fwd_bus);
    hazard1   = pick1[DW];
    hazard2   = pick2[DW];
    rs1_value = pick1[DW-1:0];
    rs2_value = pick2[DW-1:0];
    dst_full  = dst_we && (dst_addr != '0) && (cnt[dst_addr] == CMAX);
    stall     = id_valid && ((rs1_need && hazard1) || (rs2_need && hazard2) || dst_full);
  end

  // Per-register pending counters; over/underflow clamps and sets sticky err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (issue_fire && dst_we && (dst_addr == AW'(r)) && !(wb_fire && (wb_addr == AW'(r)))) begin
          if (cnt[r] == CMAX) err <= 1'b1;
          else                cnt[r] <= cnt[r] + 1'b1;
        end else if (wb_fire && (wb_addr == AW'(r)) && !(issue_fire && dst_we && (dst_addr == AW'(r)))) begin
          if (cnt[r] == '0) err <= 1'b1;
          else              cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: forwarding, hazards, occupancy and error flag.
module tb_id_scoreboard;
  localparam int AW = 5, DW = 32, NFWD = 3, NREG = 32;
  localparam int SW = 2 + AW + DW;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     rs1_addr, rs2_addr, dst_addr, wb_addr;
  logic              rs1_need, rs2_need, id_valid, dst_we, issue_fire, wb_fire;
  logic [DW-1:0]     rf_rdata1, rf_rdata2;
  logic [SW-1:0]     fwd [NFWD];
  logic [NFWD*SW-1:0] fwd_bus;
  logic [DW-1:0]     rs1_value, rs2_value;
  logic              stall, err;
  logic [NREG-1:0]   pending;
  logic [31:0]       stall_cnt;
  int total = 0;
  int bad = 0;

  assign fwd_bus = {fwd[2], fwd[1], fwd[0]};

  always #50 clk = ~clk;

  id_scoreboard dut (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs1_need(rs1_need),
    .rs2_addr(rs2_addr), .rs2_need(rs2_need), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .id_valid(id_valid), .dst_we(dst_we),
    .dst_addr(dst_addr), .issue_fire(issue_fire), .fwd_bus(fwd_bus),
    .wb_fire(wb_fire), .wb_addr(wb_addr), .rs1_value(rs1_value),
    .rs2_value(rs2_value), .stall(stall), .pending(pending), .err(err),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [SW-1:0] fe(input logic we, input logic rdy,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {we, rdy, a, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    for (int i = 0; i < NFWD; i++) fwd[i] = '0;
  endtask

  initial begin
    reset = 1'b1;
    rs1_addr = '0; rs2_addr = '0; dst_addr = '0; wb_addr = '0;
    rs1_need = 1'b0; rs2_need = 1'b0; id_valid = 1'b0; dst_we = 1'b0;
    issue_fire = 1'b0; wb_fire = 1'b0; rf_rdata1 = '0; rf_rdata2 = '0;
    clear_fwd();
    #1;
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_err", err, 0);
    check("rst_pending", pending, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Idle: plain regfile read, r0 reads as zero.
    id_valid = 1'b1; rs1_need = 1'b1; rs1_addr = 5'd3; rf_rdata1 = 32'h11;
    #1;
    check("idle_stall", stall, 0);
    check("idle_pending", pending, 0);
    check("idle_rs1", rs1_value, 32'h11);
    rs1_addr = 5'd0;
    #1;
    check("r0_value", rs1_value, 0);

    // EX producer to r5.
    issue_fire = 1'b1; dst_we = 1'b1; dst_addr = 5'd5;
    tick();
    issue_fire = 1'b0; dst_we = 1'b0;
    fwd[0] = fe(1'b1, 1'b1, 5'd5, 32'hAAAA); rs1_addr = 5'd5;
    #1;
    check("ex_fwd_value", rs1_value, 32'hAAAA);
    check("ex_fwd_stall", stall, 0);
    check("ex_pending", pending, 32'h20);

    // Load-use on r7.
    clear_fwd();
    fwd[0] = fe(1'b1, 1'b0, 5'd7, 32'h0);
    rs1_addr = 5'd3; rs2_addr = 5'd7; rs2_need = 1'b1; rf_rdata2 = 32'h99;
    #1;
    check("lu_stall", stall, 1);
    tick();
    check("lu_stall_cnt", stall_cnt, 1);
    fwd[0] = '0; fwd[1] = fe(1'b1, 1'b1, 5'd7, 32'h55);
    #1;
    check("lu_resolved_stall", stall, 0);
    check("lu_resolved_rs2", rs2_value, 32'h55);
    tick();
    check("lu_cnt_hold", stall_cnt, 1);

    // Priority: youngest matching source wins; we=0 sources are skipped.
    clear_fwd(); rs2_need = 1'b0; rs2_addr = 5'd0;
    fwd[0] = fe(1'b1, 1'b1, 5'd9, 32'h1); fwd[2] = fe(1'b1, 1'b1, 5'd9, 32'h2);
    rs1_addr = 5'd9;
    #1;
    check("prio_young", rs1_value, 32'h1);
    fwd[0] = fe(1'b0, 1'b1, 5'd9, 32'h1);
    #1;
    check("prio_skip_we0", rs1_value, 32'h2);
    fwd[0] = fe(1'b1, 1'b1, 5'd9, 32'h1); fwd[2] = fe(1'b1, 1'b0, 5'd9, 32'h2);
    #1;
    check("prio_older_notready", stall, 0);

    // Hidden producer: divide into r4.
    clear_fwd();
    issue_fire = 1'b1; dst_we = 1'b1; dst_addr = 5'd4; rs1_addr = 5'd3;
    tick();
    issue_fire = 1'b0; dst_we = 1'b0; rs1_addr = 5'd4; rf_rdata1 = 32'h44;
    #1;
    check("hid_stall", stall, 1);
    rs1_need = 1'b0;
    #1;
    check("hid_noneed", stall, 0);
    rs1_need = 1'b1; wb_fire = 1'b1; wb_addr = 5'd4;
    #1;
    check("hid_wb_edge_stall", stall, 1);
    tick();
    wb_fire = 1'b0;
    #1;
    check("hid_clear_stall", stall, 0);
    check("hid_clear_value", rs1_value, 32'h44);
    check("hid_pending", pending, 32'h20);
    check("hid_stall_cnt", stall_cnt, 2);

    // Occupancy: three writes in flight to r6 fill the counter.
    rs1_need = 1'b0; rs1_addr = 5'd0;
    issue_fire = 1'b1; dst_we = 1'b1; dst_addr = 5'd6;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("occ_fill_nostall", stall, 0);
      tick();
    end
    issue_fire = 1'b0;
    #1;
    check("occ_full_stall", stall, 1);
    check("occ_pending", pending, 32'h60);
    dst_addr = 5'd0;
    #1;
    check("occ_r0_nostall", stall, 0);
    dst_we = 1'b0; id_valid = 1'b0;
    wb_fire = 1'b1; wb_addr = 5'd6;
    tick();
    wb_fire = 1'b0; id_valid = 1'b1; dst_we = 1'b1; dst_addr = 5'd6;
    #1;
    check("occ_after_dec", stall, 0);
    // Simultaneous inc and dec on r5 leaves its count unchanged.
    dst_addr = 5'd5; issue_fire = 1'b1; wb_fire = 1'b1; wb_addr = 5'd5;
    tick();
    issue_fire = 1'b0; wb_fire = 1'b0; dst_we = 1'b0;
    #1;
    check("incdec_pending", pending, 32'h60);
    check("no_err_yet", err, 0);

    // Stray commit to r8 with nothing pending.
    id_valid = 1'b0; wb_fire = 1'b1; wb_addr = 5'd8;
    tick();
    wb_fire = 1'b0;
    #1;
    check("under_err", err, 1);
    check("under_pending", pending, 32'h60);
    tick();
    check("err_sticky", err, 1);

    // Mid-run reset clears everything.
    reset = 1'b1;
    #1;
    check("rst2_err", err, 0);
    check("rst2_pending", pending, 0);
    check("rst2_stall_cnt", stall_cnt, 0);
    tick();
    reset = 1'b0;
    tick();

    // Overflow: a fourth issue to r6 saturates rather than wrapping.
    issue_fire = 1'b1; dst_we = 1'b1; dst_addr = 5'd6;
    for (int k = 0; k < 4; k++) tick();
    issue_fire = 1'b0; dst_we = 1'b0;
    #1;
    check("over_err", err, 1);
    check("over_pending", pending, 32'h40);
    wb_fire = 1'b1; wb_addr = 5'd6;
    for (int k = 0; k < 3; k++) tick();
    wb_fire = 1'b0;
    #1;
    check("over_drained", pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
